// File: rtl/ad9231_spi_slave_if.sv
// ad9231_spi_slave_if: SPI pin bundle between an AD9231-style master and slave.
interface ad9231_spi_slave_if;
    logic ss;
    logic sck;
    logic sdi;
    logic sdo;
    logic sdo_oe;
    modport master (output ss, sck, sdi, input sdo, sdo_oe);
    modport slave (input ss, sck, sdi, output sdo, sdo_oe);
endinterface

// File: rtl/ad9231_spi_slave.sv
// ad9231_spi_slave: oversampled mode-3 SPI slave with the AD9231 shadow/commit register scheme.
module ad9231_spi_slave #(
    parameter logic [7:0] ID_VALUE = 8'h24,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstb,
    ad9231_spi_slave_if.slave spi,
    output logic [7:0] reg05_out,
    output logic [7:0] reg14_out,
    output logic update_pulse,
    output logic frame_err
);
    typedef enum logic [1:0] {IDLE, INSTR, DATA, DONE} state_t;
    state_t state, state_n;
    logic [SYNC_STAGES-1:0] ss_sync, sck_sync, sdi_sync;
    logic ss_d, sck_d, ss_s, sck_s, sdi_s;
    logic ss_fall, ss_rise, sck_rise, sck_fall;
    logic start, shift_en, abort, last_instr, last_data;
    logic [4:0] cnt;
    logic rw, rd_pend, wr_pend, tx_bit, tx_en;
    logic [12:0] addr;
    logic [7:0] dat, tx_sh, rd_val, shadow05, shadow14;
    assign ss_s = ss_sync[SYNC_STAGES-1];
    assign sck_s = sck_sync[SYNC_STAGES-1];
    assign sdi_s = sdi_sync[SYNC_STAGES-1];
    assign ss_fall = ss_d & ~ss_s;
    assign ss_rise = ~ss_d & ss_s;
    assign sck_rise = ~ss_s & ~sck_d & sck_s;
    assign sck_fall = ~ss_s & sck_d & ~sck_s;
    // ss history resets low so a frame already running at reset release never looks like a fresh select
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ss_sync <= '0;
            sck_sync <= '1;
            sdi_sync <= '0;
            ss_d <= 1'b0;
            sck_d <= 1'b1;
        end else begin
            ss_sync <= SYNC_STAGES'({ss_sync, spi.ss});
            sck_sync <= SYNC_STAGES'({sck_sync, spi.sck});
            sdi_sync <= SYNC_STAGES'({sdi_sync, spi.sdi});
            ss_d <= ss_s;
            sck_d <= sck_s;
        end
    end
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        start = 1'b0;
        shift_en = 1'b0;
        abort = 1'b0;
        last_instr = 1'b0;
        last_data = 1'b0;
        case (state)
            IDLE: begin
                start = ss_fall;
                state_n = ss_fall ? INSTR : IDLE;
            end
            INSTR, DATA: begin
                abort = ss_rise;
                shift_en = sck_rise;
                last_instr = sck_rise && state == INSTR && cnt == 5'd15;
                last_data = sck_rise && state == DATA && cnt == 5'd23;
                state_n = ss_rise ? IDLE : last_instr ? DATA : last_data ? DONE : state;
            end
            default: state_n = ss_rise ? IDLE : DONE;
        endcase
    end
    assign rd_val = addr == 13'h000 ? 8'h18 :
                    addr == 13'h001 ? ID_VALUE :
                    addr == 13'h005 ? shadow05 :
                    addr == 13'h014 ? shadow14 : 8'h00;
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt <= '0;
            rw <= 1'b0;
            addr <= '0;
            dat <= '0;
            rd_pend <= 1'b0;
            wr_pend <= 1'b0;
            tx_sh <= '0;
            tx_bit <= 1'b1;
            tx_en <= 1'b0;
            shadow05 <= 8'h03;
            shadow14 <= 8'h00;
            reg05_out <= 8'h03;
            reg14_out <= 8'h00;
            update_pulse <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rd_pend <= last_instr & rw;
            wr_pend <= last_data & ~rw;
            frame_err <= abort;
            update_pulse <= wr_pend && addr == 13'h0FF && dat == 8'h01;
            if (start) begin
                cnt <= '0;
                rw <= 1'b0;
                addr <= '0;
                dat <= '0;
            end else if (shift_en) begin
                cnt <= cnt + 5'd1;
                if (state == INSTR && cnt == 5'd0) rw <= sdi_s;
                if (state == INSTR) addr <= {addr[11:0], sdi_s};
                else dat <= {dat[6:0], sdi_s};
            end
            if (state_n != DATA) begin
                tx_en <= 1'b0;
                tx_bit <= 1'b1;
            end else if (rd_pend) begin
                tx_en <= 1'b1;
                tx_sh <= rd_val;
            end else if (sck_fall && tx_en) begin
                tx_bit <= tx_sh[7];
                tx_sh <= {tx_sh[6:0], 1'b0};
            end
            if (wr_pend && addr == 13'h005) shadow05 <= dat;
            if (wr_pend && addr == 13'h014) shadow14 <= dat;
            if (wr_pend && addr == 13'h0FF && dat == 8'h01) begin
                reg05_out <= shadow05;
                reg14_out <= shadow14;
            end
        end
    end
    assign spi.sdo = tx_bit;
    assign spi.sdo_oe = tx_en;
endmodule
